dmem_responder: RTL



---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a MemRead/MemWrite request port,
// with little-endian lane steering, load extension, misalignment checks and a wait-state ack.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  RW_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_q, wr_q;
    logic [2:0]        type_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              req, capture, enter_resp;
    logic              cur_rd, cur_wr;
    logic [2:0]        cur_type;
    logic [ADDR_W+1:0] cur_addr;
    logic              illegal;
    logic [31:0]       word;
    logic [7:0]        load_b;
    logic [15:0]       load_h;
    logic [31:0]       load_val;
    logic [3:0]        be;
    logic [31:0]       wlane;

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    assign req = MemRead | MemWrite;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign enter_resp = (state_d == StResp) && (state_q != StResp);

    // With zero wait states RESP is entered on the accept edge, so use the live inputs.
    always_comb begin
        if (state_q == StIdle) begin
            cur_rd   = MemRead;
            cur_wr   = MemWrite;
            cur_type = RW_type;
            cur_addr = addr[ADDR_W+1:0];
        end else begin
            cur_rd   = rd_q;
            cur_wr   = wr_q;
            cur_type = type_q;
            cur_addr = addr_q;
        end
    end

    always_comb begin
        illegal = 1'b0;
        if (cur_rd && cur_wr) illegal = 1'b1;
        if (cur_rd && (cur_type == 3'b011 || cur_type[2:1] == 2'b11)) illegal = 1'b1;
        if (cur_wr && !(cur_type == 3'b000 || cur_type == 3'b001 || cur_type == 3'b010)) begin
            illegal = 1'b1;
        end
        if (cur_type[1:0] == 2'b01 && cur_addr[0]) illegal = 1'b1;
        if (cur_type[1:0] == 2'b10 && cur_addr[1:0] != 2'b00) illegal = 1'b1;
    end

    always_comb begin
        word   = mem[cur_addr[ADDR_W+1:2]];
        load_b = word[{cur_addr[1:0], 3'b000} +: 8];
        load_h = cur_addr[1] ? word[31:16] : word[15:0];
        case (cur_type)
            3'b000:  load_val = {{24{load_b[7]}}, load_b};
            3'b100:  load_val = {24'd0, load_b};
            3'b001:  load_val = {{16{load_h[15]}}, load_h};
            3'b101:  load_val = {16'd0, load_h};
            default: load_val = word;
        endcase
    end

    always_comb begin
        case (type_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            type_q  <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                rd_q    <= MemRead;
                wr_q    <= MemWrite;
                type_q  <= RW_type;
                addr_q  <= addr[ADDR_W+1:0];
                wdata_q <= wdata;
            end
            if (enter_resp) begin
                err_q   <= illegal;
                rdata_q <= (illegal || !cur_rd) ? 32'd0 : load_val;
            end else begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // Store commits on the edge ending RESP; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == StResp && wr_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr_q[ADDR_W+1:2]][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    assign ack   = (state_q == StResp);
    assign busy  = (state_q != StIdle);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule
